// File: rtl/bus_txn_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : bus_txn_watchdog
//  Description : Per-CPU bus transaction watchdog. Times each request from
//                assertion to ack, flags requests that reach the programmed
//                cycle limit, captures the first offender. Optional latency
//                statistics are built when BUS_WD_STATS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_txn_watchdog #(
    parameter int NUM_CPUS  = 8,
    parameter int TIMEOUT_W = 16,
    parameter int CPU_ID_W  = $clog2(NUM_CPUS)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NUM_CPUS-1:0]  req,
    input  logic [NUM_CPUS-1:0]  ack,
    input  logic [TIMEOUT_W-1:0] timeout_cfg,
    input  logic                 clear,
    output logic [NUM_CPUS-1:0]  timeout_vec,
    output logic [NUM_CPUS-1:0]  busy_vec,
    output logic                 err_valid,
    output logic [CPU_ID_W-1:0]  err_cpu,
    output logic [TIMEOUT_W-1:0] max_latency,
    output logic [CPU_ID_W-1:0]  max_cpu
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_e;

    logic [NUM_CPUS-1:0] enter_vec;

`ifdef BUS_WD_STATS_EN
    logic [NUM_CPUS-1:0]                done_vec;
    logic [NUM_CPUS-1:0][TIMEOUT_W-1:0] lat_arr;
`endif

    genvar i;
    generate
        for (i = 0; i < NUM_CPUS; i++) begin : g_chan
            state_e               state_q, state_d;
            logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
            logic                 enter;

            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                enter   = 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        if (req[i]) begin
                            state_d = ST_WAIT;
                            cnt_d   = TIMEOUT_W'(1);
                        end
                    end
                    ST_WAIT: begin
                        // Ack has priority over a limit hit in the same cycle.
                        if (ack[i]) begin
                            state_d = ST_IDLE;
                        end else if (!req[i]) begin
                            state_d = ST_IDLE;
                        end else if ((timeout_cfg != '0) && (cnt_q == timeout_cfg)) begin
                            state_d = ST_TIMEOUT;
                            enter   = 1'b1;
                        end else if (cnt_q != '1) begin
                            cnt_d = cnt_q + TIMEOUT_W'(1);
                        end
                    end
                    ST_TIMEOUT: begin
                        if (ack[i] || !req[i]) begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign enter_vec[i] = enter;
            assign busy_vec[i]  = (state_q != ST_IDLE);
`ifdef BUS_WD_STATS_EN
            assign done_vec[i]  = (state_q == ST_WAIT) && ack[i];
            assign lat_arr[i]   = cnt_q;
`endif
        end
    endgenerate

    // ------------------------------------------------------------------
    // Sticky flags and first-offender capture
    // ------------------------------------------------------------------
    logic [NUM_CPUS-1:0] timeout_vec_q, timeout_vec_d;
    logic                err_valid_q, err_valid_d;
    logic [CPU_ID_W-1:0] err_cpu_q, err_cpu_d;
    logic [CPU_ID_W-1:0] first_cpu;

    always_comb begin
        first_cpu = '0;
        for (int k = NUM_CPUS - 1; k >= 0; k--) begin
            if (enter_vec[k]) first_cpu = CPU_ID_W'(k);
        end

        // New timeouts land on top of the cleared value so they survive a clear.
        timeout_vec_d = (clear ? '0 : timeout_vec_q) | enter_vec;
        err_valid_d   = clear ? 1'b0 : err_valid_q;
        err_cpu_d     = clear ? '0   : err_cpu_q;
        if ((enter_vec != '0) && !err_valid_d) begin
            err_valid_d = 1'b1;
            err_cpu_d   = first_cpu;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            timeout_vec_q <= '0;
            err_valid_q   <= 1'b0;
            err_cpu_q     <= '0;
        end else begin
            timeout_vec_q <= timeout_vec_d;
            err_valid_q   <= err_valid_d;
            err_cpu_q     <= err_cpu_d;
        end
    end

    assign timeout_vec = timeout_vec_q;
    assign err_valid   = err_valid_q;
    assign err_cpu     = err_cpu_q;

    // ------------------------------------------------------------------
    // Optional latency statistics
    // ------------------------------------------------------------------
`ifdef BUS_WD_STATS_EN
    logic [TIMEOUT_W-1:0] max_latency_q, max_latency_d;
    logic [CPU_ID_W-1:0]  max_cpu_q, max_cpu_d;
    logic                 best_found;
    logic [TIMEOUT_W-1:0] best_cnt;
    logic [CPU_ID_W-1:0]  best_cpu;

    always_comb begin
        best_found = 1'b0;
        best_cnt   = '0;
        best_cpu   = '0;
        // Strict compare while scanning upward keeps the lowest index on ties.
        for (int k = 0; k < NUM_CPUS; k++) begin
            if (done_vec[k] && (!best_found || (lat_arr[k] > best_cnt))) begin
                best_found = 1'b1;
                best_cnt   = lat_arr[k];
                best_cpu   = CPU_ID_W'(k);
            end
        end

        max_latency_d = clear ? '0 : max_latency_q;
        max_cpu_d     = clear ? '0 : max_cpu_q;
        if (best_found && (best_cnt > max_latency_d)) begin
            max_latency_d = best_cnt;
            max_cpu_d     = best_cpu;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            max_latency_q <= '0;
            max_cpu_q     <= '0;
        end else begin
            max_latency_q <= max_latency_d;
            max_cpu_q     <= max_cpu_d;
        end
    end

    assign max_latency = max_latency_q;
    assign max_cpu     = max_cpu_q;
`else
    assign max_latency = '0;
    assign max_cpu     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_txn_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_txn_watchdog
//  Description : Self-checking bench for bus_txn_watchdog; directed scenarios
//                plus random traffic against a timestamp-based reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_txn_watchdog;

    localparam int NUM     = 8;
    localparam int TW      = 16;
    localparam int CW      = 3;
    localparam int CNT_MAX = (1 << TW) - 1;
`ifdef BUS_WD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic           CLK;
    logic           RST;
    logic [NUM-1:0] req;
    logic [NUM-1:0] ack;
    logic [TW-1:0]  timeout_cfg;
    logic           clear;
    logic [NUM-1:0] timeout_vec;
    logic [NUM-1:0] busy_vec;
    logic           err_valid;
    logic [CW-1:0]  err_cpu;
    logic [TW-1:0]  max_latency;
    logic [CW-1:0]  max_cpu;

    bus_txn_watchdog #(.NUM_CPUS(NUM), .TIMEOUT_W(TW)) dut (
        .CLK(CLK), .RST(RST), .req(req), .ack(ack), .timeout_cfg(timeout_cfg),
        .clear(clear), .timeout_vec(timeout_vec), .busy_vec(busy_vec),
        .err_valid(err_valid), .err_cpu(err_cpu), .max_latency(max_latency),
        .max_cpu(max_cpu)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference: a transaction is the edge number at which its request was
    // first sampled; its age at a later edge is the elapsed edge count.
    int       m_start [NUM];
    bit       m_trip  [NUM];
    logic [NUM-1:0] m_tovec;
    bit       m_errv;
    int       m_errc, m_maxl, m_maxc;
    int       cyc;

    task automatic model_reset();
        for (int i = 0; i < NUM; i++) begin
            m_start[i] = -1;
            m_trip[i]  = 1'b0;
        end
        m_tovec = '0; m_errv = 1'b0; m_errc = 0; m_maxl = 0; m_maxc = 0;
        cyc = 0;
    endtask

    task automatic model_step();
        logic [NUM-1:0] newto;
        int bestc, besti, age;
        newto = '0; bestc = -1; besti = 0;
        for (int i = 0; i < NUM; i++) begin
            if (m_start[i] < 0) begin
                if (req[i]) m_start[i] = cyc;
            end else begin
                age = cyc - m_start[i];
                if (age > CNT_MAX) age = CNT_MAX;
                if (m_trip[i]) begin
                    if (ack[i] || !req[i]) begin
                        m_start[i] = -1;
                        m_trip[i]  = 1'b0;
                    end
                end else if (ack[i]) begin
                    if (age > bestc) begin bestc = age; besti = i; end
                    m_start[i] = -1;
                end else if (!req[i]) begin
                    m_start[i] = -1;
                end else if (timeout_cfg != 0 && age == int'(timeout_cfg)) begin
                    m_trip[i] = 1'b1;
                    newto[i]  = 1'b1;
                end
            end
        end
        if (clear) begin
            m_tovec = '0; m_errv = 1'b0; m_errc = 0; m_maxl = 0; m_maxc = 0;
        end
        m_tovec |= newto;
        if (newto != '0 && !m_errv) begin
            m_errv = 1'b1;
            for (int i = NUM - 1; i >= 0; i--) if (newto[i]) m_errc = i;
        end
        if (STATS && bestc > m_maxl) begin
            m_maxl = bestc;
            m_maxc = besti;
        end
        cyc++;
    endtask

    task automatic check_all();
        logic [NUM-1:0] busy_exp;
        for (int i = 0; i < NUM; i++) busy_exp[i] = (m_start[i] >= 0);
        chk("timeout_vec", 32'(timeout_vec), 32'(m_tovec));
        chk("busy_vec",    32'(busy_vec),    32'(busy_exp));
        chk("err_valid",   32'(err_valid),   32'(m_errv));
        chk("err_cpu",     32'(err_cpu),     32'(m_errc));
        chk("max_latency", 32'(max_latency), 32'(m_maxl));
        chk("max_cpu",     32'(max_cpu),     32'(m_maxc));
    endtask

    // Inputs are applied at the falling edge; the model is advanced for the
    // coming rising edge and outputs are compared at the following falling edge.
    task automatic cycle();
        model_step();
        @(posedge CLK);
        @(negedge CLK);
        check_all();
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic quiesce();
        req = '0; ack = '0; clear = 1'b1;
        cycle();
        clear = 1'b0;
        cycle();
    endtask

    initial begin
        RST = 1'b1; req = '0; ack = '0; timeout_cfg = '0; clear = 1'b0;
        model_reset();
        @(negedge CLK); @(negedge CLK);
        chk("rst_timeout_vec", 32'(timeout_vec), 32'h0);
        chk("rst_busy_vec",    32'(busy_vec),    32'h0);
        chk("rst_err_valid",   32'(err_valid),   32'h0);
        chk("rst_err_cpu",     32'(err_cpu),     32'h0);
        chk("rst_max_latency", 32'(max_latency), 32'h0);
        chk("rst_max_cpu",     32'(max_cpu),     32'h0);
        RST = 1'b0;
        cycle();

        // Single-channel timeout
        timeout_cfg = 16'd5; req = 8'h08;
        cycles(5);
        chk("t1_before_limit", 32'(timeout_vec), 32'h0);
        chk("t1_busy_early",   32'(busy_vec[3]), 32'h1);
        cycle();
        chk("t1_timeout_vec", 32'(timeout_vec), 32'h08);
        chk("t1_err_valid",   32'(err_valid),   32'h1);
        chk("t1_err_cpu",     32'(err_cpu),     32'h3);
        cycles(3);
        chk("t1_busy_held", 32'(busy_vec[3]), 32'h1);
        req = 8'h00;
        cycle();
        chk("t1_busy_drop", 32'(busy_vec[3]), 32'h0);
        quiesce();

        // Ack exactly when cnt equals the limit
        timeout_cfg = 16'd5; req = 8'h01;
        cycles(5);
        ack = 8'h01;
        cycle();
        ack = 8'h00; req = 8'h00;
        chk("t2_no_flag", 32'(timeout_vec), 32'h0);
        chk("t2_idle",    32'(busy_vec[0]), 32'h0);
        chk("t2_max_lat", 32'(max_latency), STATS ? 32'd5 : 32'd0);
        chk("t2_max_cpu", 32'(max_cpu),     32'd0);
        cycle();
        quiesce();

        // Simultaneous timeouts, then a later one
        timeout_cfg = 16'd4; req = 8'h44;
        cycles(5);
        chk("t3_vec",     32'(timeout_vec), 32'h44);
        chk("t3_err_cpu", 32'(err_cpu),     32'h2);
        req[7] = 1'b1;
        cycles(5);
        chk("t3_vec_late",     32'(timeout_vec), 32'hC4);
        chk("t3_err_cpu_late", 32'(err_cpu),     32'h2);
        quiesce();

        // Clear colliding with a timeout entry
        timeout_cfg = 16'd3; req = 8'h10;
        cycles(4);
        chk("t4_prior_vec", 32'(timeout_vec), 32'h10);
        req = 8'h00;
        cycle();
        req = 8'h02;
        cycles(3);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        chk("t4_vec",       32'(timeout_vec), 32'h02);
        chk("t4_err_valid", 32'(err_valid),   32'h1);
        chk("t4_err_cpu",   32'(err_cpu),     32'h1);
        quiesce();

        // Detection disabled, long hold, abort, then saturation probe
        timeout_cfg = 16'd0; req = 8'h30;
        cycles(70000);
        chk("t5_no_flag", 32'(timeout_vec), 32'h0);
        chk("t5_busy",    32'(busy_vec),    32'h30);
        req[5] = 1'b0;
        cycle();
        chk("t5_abort_idle", 32'(busy_vec),    32'h10);
        chk("t5_abort_flag", 32'(timeout_vec), 32'h0);
        timeout_cfg = 16'hFFFF;
        cycle();
        chk("t5_saturated", 32'(timeout_vec), 32'h10);
        timeout_cfg = 16'd5;
        quiesce();

        // Asynchronous reset with four channels mid-transaction
        timeout_cfg = 16'd6; req = 8'h0F;
        cycles(3);
        #2 RST = 1'b1;
        #1;
        chk("t6_async_busy", 32'(busy_vec),    32'h0);
        chk("t6_async_vec",  32'(timeout_vec), 32'h0);
        chk("t6_async_errv", 32'(err_valid),   32'h0);
        req = '0;
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        timeout_cfg = 16'd3; req = 8'h04;
        cycles(4);
        chk("t6_restart_vec", 32'(timeout_vec), 32'h04);
        chk("t6_restart_cpu", 32'(err_cpu),     32'h2);
        quiesce();

        // Random traffic
        timeout_cfg = 16'd6;
        for (int n = 0; n < 5000; n++) begin
            if ($urandom_range(0, 49) == 0) timeout_cfg = 16'($urandom_range(0, 12));
            for (int ch = 0; ch < NUM; ch++) begin
                if (req[ch]) begin
                    if ($urandom_range(0, 15) == 0) req[ch] = 1'b0;
                end else if ($urandom_range(0, 7) == 0) begin
                    req[ch] = 1'b1;
                end
                ack[ch] = ($urandom_range(0, 11) == 0);
            end
            clear = ($urandom_range(0, 39) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
